// File: rtl/hist_cdf_pkg.sv
// Shared types and saturating arithmetic for the histogram/CDF engine.
// The helpers use a 32-bit container, and the caller passes the real counter width.
package hist_cdf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FETCH,
      WAIT,
      COUNT,
      CDF,
      DONE
   } state_t;

   localparam logic MODE_CDF  = 1'b0;
   localparam logic MODE_HIST = 1'b1;

   localparam int MAX_CNT_W = 32;
   typedef logic [MAX_CNT_W-1:0] cnt_t;
   typedef logic [MAX_CNT_W:0]   wide_t;

   // Operands must already fit in w bits; the result clips at 2**w-1.
   function automatic cnt_t satAdd(input cnt_t a, input cnt_t b, input int unsigned w);
      wide_t sum;
      wide_t lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (wide_t'(1) << w) - wide_t'(1);
      return (sum > lim) ? lim[MAX_CNT_W-1:0] : sum[MAX_CNT_W-1:0];
   endfunction

   function automatic cnt_t satInc(input cnt_t a, input int unsigned w);
      return satAdd(a, cnt_t'(1), w);
   endfunction

endpackage

// File: rtl/hist_lane_unpack.sv
// Holds one packed input word and presents one pixel per shift, lane 0 first.
// last_o marks the final lane so the engine knows when a word is consumed.
module hist_lane_unpack #(
   parameter int PIX_W = 8,
   parameter int LANES = 16
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic                   load_i,
   input  logic                   shift_i,
   input  logic [PIX_W*LANES-1:0] data_i,
   output logic [PIX_W-1:0]       pixel_o,
   output logic                   last_o
);

   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic [PIX_W*LANES-1:0] data_q;
   logic [LANE_W-1:0]      lane_q;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         lane_q <= '0;
      end else if (load_i) begin
         data_q <= data_i;
         lane_q <= '0;
      end else if (shift_i) begin
         data_q <= data_q >> PIX_W;
         lane_q <= lane_q + 1'b1;
      end
   end

   assign pixel_o = data_q[PIX_W-1:0];
   assign last_o  = (lane_q == LANE_W'(LANES - 1));

endmodule

// File: rtl/hist_cdf_engine.sv
// Streams packed pixel words into a saturating histogram bank and then writes
// either the running CDF or the raw bins to the output SRAM, one entry per bin.
module hist_cdf_engine
   import hist_cdf_pkg::*;
#(
   parameter int PIX_W  = 8,
   parameter int LANES  = 16,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 20
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   mode,
   input  logic [ADDR_W:0]        num_words,
   input  logic [ADDR_W-1:0]      in_base,
   input  logic [ADDR_W-1:0]      out_base,
   output logic [ADDR_W-1:0]      rd_addr,
   input  logic [PIX_W*LANES-1:0] rd_data,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [PIX_W*LANES-1:0] wr_data,
   output logic                   we,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       cdf_min,
   output logic                   cdf_valid
);

   localparam int BINS   = 2 ** PIX_W;
   localparam int DATA_W = PIX_W * LANES;

   state_t              state_q, state_d;
   logic                mode_q, mode_d;
   logic [ADDR_W:0]     numWords_q, numWords_d;
   logic [ADDR_W:0]     wordIdx_q, wordIdx_d;
   logic [ADDR_W-1:0]   inBase_q, inBase_d;
   logic [ADDR_W-1:0]   outBase_q, outBase_d;
   logic [ADDR_W-1:0]   rdAddr_q, rdAddr_d;
   logic [PIX_W-1:0]    binIdx_q, binIdx_d;
   logic [CNT_W-1:0]    sum_q, sum_d;
   logic [CNT_W-1:0]    cdfMin_q, cdfMin_d;
   logic                done_q, done_d;
   logic                cdfValid_q, cdfValid_d;
   logic [CNT_W-1:0]    bin_q [BINS];

   logic [PIX_W-1:0]    pixel;
   logic                lastLane;
   logic [CNT_W-1:0]    binRead;
   logic [CNT_W-1:0]    sumNext;

   hist_lane_unpack #(
      .PIX_W (PIX_W),
      .LANES (LANES)
   ) unpack (
      .clock   (clock),
      .rst     (rst),
      .load_i  (state_q == WAIT),
      .shift_i (state_q == COUNT),
      .data_i  (rd_data),
      .pixel_o (pixel),
      .last_o  (lastLane)
   );

   assign binRead = bin_q[binIdx_q];
   assign sumNext = CNT_W'(satAdd(cnt_t'(sum_q), cnt_t'(binRead), CNT_W));

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= MODE_CDF;
         numWords_q <= '0;
         wordIdx_q  <= '0;
         inBase_q   <= '0;
         outBase_q  <= '0;
         rdAddr_q   <= '0;
         binIdx_q   <= '0;
         sum_q      <= '0;
         cdfMin_q   <= '0;
         done_q     <= 1'b0;
         cdfValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         numWords_q <= numWords_d;
         wordIdx_q  <= wordIdx_d;
         inBase_q   <= inBase_d;
         outBase_q  <= outBase_d;
         rdAddr_q   <= rdAddr_d;
         binIdx_q   <= binIdx_d;
         sum_q      <= sum_d;
         cdfMin_q   <= cdfMin_d;
         done_q     <= done_d;
         cdfValid_q <= cdfValid_d;
      end
   end

   // The counter bank is wiped in CLEAR so a run never inherits old counts.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < BINS; b++) bin_q[b] <= '0;
      end else if (state_q == CLEAR) begin
         for (int b = 0; b < BINS; b++) bin_q[b] <= '0;
      end else if (state_q == COUNT) begin
         bin_q[pixel] <= CNT_W'(satInc(cnt_t'(bin_q[pixel]), CNT_W));
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      numWords_d = numWords_q;
      wordIdx_d  = wordIdx_q;
      inBase_d   = inBase_q;
      outBase_d  = outBase_q;
      rdAddr_d   = rdAddr_q;
      binIdx_d   = binIdx_q;
      sum_d      = sum_q;
      cdfMin_d   = cdfMin_q;
      done_d     = done_q;
      cdfValid_d = cdfValid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d     = mode;
               numWords_d = num_words;
               inBase_d   = in_base;
               outBase_d  = out_base;
               cdfMin_d   = '0;
               done_d     = 1'b0;
               cdfValid_d = 1'b0;
               state_d    = CLEAR;
            end
         end
         CLEAR: begin
            wordIdx_d = '0;
            binIdx_d  = '0;
            sum_d     = '0;
            state_d   = (numWords_q == '0) ? CDF : FETCH;
         end
         FETCH: state_d = WAIT;
         WAIT:  state_d = COUNT;
         COUNT: begin
            if (lastLane) begin
               wordIdx_d = wordIdx_q + 1'b1;
               state_d   = (wordIdx_d == numWords_q) ? CDF : FETCH;
            end
         end
         CDF: begin
            sum_d    = sumNext;
            binIdx_d = binIdx_q + 1'b1;
            // The running sum never decreases, so the first non-zero value is the minimum.
            if (mode_q == MODE_CDF && cdfMin_q == '0 && sumNext != '0) cdfMin_d = sumNext;
            if (binIdx_q == PIX_W'(BINS - 1)) begin
               done_d     = 1'b1;
               cdfValid_d = (mode_q == MODE_CDF);
               state_d    = DONE;
            end
         end
         DONE: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // The address is registered as FETCH is entered, so the SRAM sees it during FETCH.
      if (state_d == FETCH) rdAddr_d = inBase_q + wordIdx_d[ADDR_W-1:0];
   end

   assign rd_addr   = rdAddr_q;
   assign we        = (state_q == CDF);
   assign wr_addr   = we ? (outBase_q + ADDR_W'(binIdx_q)) : '0;
   assign wr_data   = we ? DATA_W'((mode_q == MODE_HIST) ? binRead : sumNext) : '0;
   assign busy      = (state_q inside {CLEAR, FETCH, WAIT, COUNT, CDF});
   assign done      = done_q;
   assign cdf_min   = cdfMin_q;
   assign cdf_valid = cdfValid_q;

endmodule

// File: doc/hist_cdf_engine.md
Name: hist_cdf_engine

Overview:
- Parametrised successor of the input pipeline histogram/CDF front end.
- Streams packed pixel words from the input SRAM and builds a histogram in an internal counter bank.
- Then writes either the cumulative distribution or the raw histogram to the output SRAM, one entry per word, and reports cdf_min for the equalisation stage.
- Adds runtime word count, base offsets, selectable mode, a busy flag, and saturating counts.

Parameters:
- PIX_W, 8, bits per pixel; bin count BINS = 2**PIX_W.
- LANES, 16, pixels per memory word; DATA_W = PIX_W*LANES (128 at defaults).
- ADDR_W, 16, SRAM address width.
- CNT_W, 20, histogram/CDF counter width.

Ports:
- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  level request; sampled in IDLE.
- mode  in  1  0 = CDF output, 1 = raw histogram output.
- num_words  in  ADDR_W+1  input words to process (0..2**ADDR_W).
- in_base  in  ADDR_W  first input word address.
- out_base  in  ADDR_W  first output word address.
- rd_addr  out  ADDR_W  input SRAM read address.
- rd_data  in  DATA_W  input SRAM read data; lane k = bits [k*PIX_W +: PIX_W].
- wr_addr  out  ADDR_W  output SRAM write address.
- wr_data  out  DATA_W  output entry, zero-extended from CNT_W.
- we  out  1  output SRAM write enable.
- busy  out  1  high from the CLEAR state through the CDF state.
- done  out  1  high in the DONE state.
- cdf_min  out  CNT_W  first non-zero cumulative count.
- cdf_valid  out  1  cdf_min is valid.

Behaviour:
- Reset (asynchronous, any state):
  - state returns to IDLE.
  - All outputs return to 0: rd_addr, wr_addr, wr_data, we, busy, done, cdf_min, cdf_valid.
  - All bins are cleared.
  - A reset mid-operation aborts with no further writes; we drops immediately.
- Read timing: rd_data is valid on the clock edge after rd_addr is presented (1-cycle SRAM latency).
- IDLE: when start=1, latch mode, num_words, in_base and out_base, then go to CLEAR.
- CLEAR: 1 cycle. All BINS counters are zeroed. Word index i=0. Next state is FETCH, or CDF if num_words=0.
- FETCH: drive rd_addr = in_base+i (mod 2**ADDR_W), then go to WAIT.
- WAIT: capture rd_data into the lane shift register, then go to COUNT.
- COUNT: LANES cycles, lane 0 first, one bin increment per cycle.
  - Counters saturate at 2**CNT_W-1.
  - After the last lane, i++. If i==num_words go to CDF, else go to FETCH.
  - Throughput is LANES+2 cycles per word.
- CDF: BINS cycles, b = 0..BINS-1.
  - Running sum s += bin[b], saturating at CNT_W.
  - Drive we=1, wr_addr = out_base+b (wrapping), wr_data = (mode ? bin[b] : s).
  - mode=0: cdf_min latches s on the first b where s != 0.
  - Then go to DONE.
- DONE:
  - done=1.
  - cdf_valid = (mode==0).
  - cdf_min holds; it is 0 if every bin was empty.
  - Stay in DONE while start=1; return to IDLE when start=0.
  - done and cdf_valid hold until the next CLEAR, then clear to 0.
- start changing outside IDLE/DONE is ignored.
- Input changes to num_words, in_base, out_base or mode after latching are ignored.
- we is 0 outside CDF. Exactly BINS writes occur per run.

Decomposition:
- Package hist_cdf_pkg holds:
  - the state enum (IDLE, CLEAR, FETCH, WAIT, COUNT, CDF, DONE);
  - the MODE_CDF and MODE_HIST constants;
  - a saturating-increment function and a saturating-add function of width CNT_W.
- Sub-module hist_lane_unpack:
  - loads a DATA_W word and shifts out one PIX_W pixel per cycle, LSB lane first;
  - raises a last flag on lane LANES-1.

Test Plan:
- num_words=2, in_base=0x10, every pixel = 0x00, mode=0 -> bin0 = 32; all 256 writes to out_base..out_base+255 read 32; cdf_min=32; cdf_valid=1; done after 1+2*18+256 cycles.
- One word with pixels 0x00..0x0F, mode=1 -> wr_data[0..15]=1, wr_data[16..255]=0; cdf_valid=0; cdf_min=0.
- Same word, mode=0, out_base=0xFF80 -> addresses wrap 0xFF80..0x007F; wr_data[b] = min(b+1, 16); cdf_min=1.
- num_words=0 -> 256 zero writes; cdf_min=0; cdf_valid=1; no rd_addr activity beyond the reset value.
- num_words=65536, all pixels 0x05, mode=0 -> bin5 saturates at 0xFFFFF; CDF is 0 for b<5 and 0xFFFFF for b≥5; cdf_min=0xFFFFF.
- rst asserted mid-COUNT, then start re-issued with num_words=1 -> we never asserts before the new run; results match a clean single-word run.
